aes_req_arbiter: RTL

- Shares one AES-128 encryption core between NUM_REQ independent requesters.
- Each requester has a valid/ready request channel (key plus plaintext) and a valid/ready response channel (ciphertext plus error flag).
- The arbiter grants one requester at a time in round-robin order, issues a single-cycle load to the core, waits for the core's done pulse, and returns the result to the granted requester only.
- It sits between the tile's crypto requesters and the existing aes wrapper, driving that wrapper's ld/key/text_in and consuming its done/text_out.

---
 rtl/aes_arb_pkg.sv | 14 +
 rtl/rr_pick.sv | 25 ++
 rtl/aes_req_arbiter.sv | 119 +++++++++++
 3 files changed

// File: rtl/aes_arb_pkg.sv
// Shared definitions for the AES request arbiter and related crypto-sharing blocks.
package aes_arb_pkg;

    localparam int AES_BLK_W       = 128;
    localparam int TIMEOUT_CYC_DEF = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } arb_state_e;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: first set request bit at or above rr_ptr, wrapping.
module rr_pick #(
    parameter int  NUM_REQ = 4,
    localparam int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDW-1:0]     rr_ptr,
    output logic               any,
    output logic [IDW-1:0]     idx
);

    always_comb begin
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        any = 1'b0;
        idx = '0;
        // Scan farthest offset first so the nearest requester at or after rr_ptr is the last writer.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (req[(int'(rr_ptr) + k) % NUM_REQ]) begin
                any = 1'b1;
                idx = IDW'((int'(rr_ptr) + k) % NUM_REQ);
            end
        end
    end

endmodule

// File: rtl/aes_req_arbiter.sv
// Round-robin arbiter sharing one AES-128 core between NUM_REQ valid/ready requesters.
module aes_req_arbiter
    import aes_arb_pkg::*;
#(
    parameter int  NUM_REQ     = 4,
    parameter int  TIMEOUT_CYC = TIMEOUT_CYC_DEF,
    localparam int IDW         = $clog2(NUM_REQ)
) (
    input  logic                           sys_clk,
    input  logic                           sys_rst_n,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*AES_BLK_W-1:0]   req_key,
    input  logic [NUM_REQ*AES_BLK_W-1:0]   req_text,
    output logic [NUM_REQ-1:0]             rsp_valid,
    input  logic [NUM_REQ-1:0]             rsp_ready,
    output logic [AES_BLK_W-1:0]           rsp_text,
    output logic                           rsp_err,
    output logic                           aes_ld,
    output logic [AES_BLK_W-1:0]           aes_key,
    output logic [AES_BLK_W-1:0]           aes_text_in,
    input  logic                           aes_done,
    input  logic [AES_BLK_W-1:0]           aes_text_out,
    output logic                           busy,
    output logic                           timeout_err
);

    arb_state_e     state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] grant_idx;
    logic [IDW-1:0] pick_idx;
    logic [IDW-1:0] next_ptr;
    logic [7:0]     wait_cnt;
    logic           any_req;
    logic           req_hs;
    logic           rsp_hs;
    logic           wait_expired;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req    (req_valid),
        .rr_ptr (rr_ptr),
        .any    (any_req),
        .idx    (pick_idx)
    );

    // Gating with reset keeps req_ready low while reset is held even if requesters are valid.
    assign req_hs       = (state == IDLE) && any_req && sys_rst_n;
    assign rsp_hs       = (state == RESP) && rsp_ready[grant_idx];
    assign wait_expired = (wait_cnt == 8'(TIMEOUT_CYC - 1));
    assign next_ptr     = (grant_idx == IDW'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;

    assign aes_ld = (state == LOAD);
    assign busy   = (state != IDLE);

    always_comb begin
        req_ready = '0;
        rsp_valid = '0;
        if (req_hs) begin
            req_ready[pick_idx] = 1'b1;
        end
        if (state == RESP) begin
            rsp_valid[grant_idx] = 1'b1;
        end
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values and updates together.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_idx   <= '0;
            wait_cnt    <= '0;
            aes_key     <= '0;
            aes_text_in <= '0;
            rsp_text    <= '0;
            rsp_err     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_hs) begin
                        aes_key     <= req_key[pick_idx * AES_BLK_W +: AES_BLK_W];
                        aes_text_in <= req_text[pick_idx * AES_BLK_W +: AES_BLK_W];
                        grant_idx   <= pick_idx;
                        state       <= LOAD;
                    end
                end
                LOAD: begin
                    wait_cnt <= '0;
                    state    <= WAIT;
                end
                WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    // A done arriving in the last allowed cycle still counts as a normal result.
                    if (aes_done) begin
                        rsp_text <= aes_text_out;
                        rsp_err  <= 1'b0;
                        state    <= RESP;
                    end else if (wait_expired) begin
                        rsp_text    <= '0;
                        rsp_err     <= 1'b1;
                        timeout_err <= 1'b1;
                        state       <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_hs) begin
                        rr_ptr <= next_ptr;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
